// File: rtl/msg_slot_scheduler.sv
// msg_slot_scheduler
// Takes one stage-2 beat (up to three message slots with their N-type and
// mux controls) into a local buffer and replays the valid slots one per
// cycle under a valid/ready handshake. Upstream is held off while a block
// drains. When the last message of a block transfers, the next beat can be
// accepted in the same cycle, so back-to-back blocks have no bubble.
// Optional build macro: MSG_SCHED_STATS_EN adds saturating beat/message
// counters on blk_cnt_out and msg_cnt_out.
module msg_slot_scheduler #(
   parameter int MSG_W   = 128,
   parameter int NTYPE_W = 4,
   parameter int MUX_W   = 3
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [MSG_W-1:0]   msg1_in,
   input  logic [MSG_W-1:0]   msg2_in,
   input  logic [MSG_W-1:0]   msg3_in,
   input  logic [NTYPE_W-1:0] ntype_m1_in,
   input  logic [NTYPE_W-1:0] ntype_m2_in,
   input  logic [NTYPE_W-1:0] ntype_m3_in,
   input  logic [MUX_W-1:0]   mux_m1_in,
   input  logic [MUX_W-1:0]   mux_m2_in,
   input  logic [MUX_W-1:0]   mux_m3_in,
   input  logic [1:0]         msg_num_in,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [MSG_W-1:0]   out_msg,
   output logic [NTYPE_W-1:0] out_ntype,
   output logic [MUX_W-1:0]   out_mux,
   output logic [1:0]         out_idx,
   output logic               out_last
`ifdef MSG_SCHED_STATS_EN
   ,
   output logic [15:0]        blk_cnt_out,
   output logic [15:0]        msg_cnt_out
`endif
);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t state_q;
   state_t state_d;

   // Block buffer: one entry per message slot plus the block's message count
   logic [MSG_W-1:0]   msg_p0   [3];
   logic [NTYPE_W-1:0] ntype_p0 [3];
   logic [MUX_W-1:0]   mux_p0   [3];
   logic [1:0]         count_p0;
   logic [1:0]         idx_p0;

   logic [1:0]         idx_d;
   logic               load;
   logic               last_slot;
   logic               accept;
   logic               xfer;

   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;
   // count is 1..3 whenever this matters (SEND), so count-1 never wraps
   assign last_slot = (idx_p0 == (count_p0 - 2'd1));

   // Next-state, buffer load and handshake decode
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_p0;
      load      = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            // a zero-count beat is consumed here with nothing to emit
            if (in_valid && (msg_num_in != 2'd0)) begin
               load    = 1'b1;
               idx_d   = 2'd0;
               state_d = SEND;
            end
         end
         SEND: begin
            out_valid = 1'b1;
            out_last  = last_slot;
            if (out_ready) begin
               if (!last_slot) begin
                  idx_d = idx_p0 + 2'd1;
               end else begin
                  // block finishes this cycle, so a new beat may land now
                  in_ready = 1'b1;
                  idx_d    = 2'd0;
                  if (in_valid && (msg_num_in != 2'd0)) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            idx_d   = 2'd0;
         end
      endcase
   end

   // Output slot select from the buffer at the current index
   always_comb begin
      out_msg   = msg_p0[0];
      out_ntype = ntype_p0[0];
      out_mux   = mux_p0[0];
      case (idx_p0)
         2'd1: begin
            out_msg   = msg_p0[1];
            out_ntype = ntype_p0[1];
            out_mux   = mux_p0[1];
         end
         2'd2: begin
            out_msg   = msg_p0[2];
            out_ntype = ntype_p0[2];
            out_mux   = mux_p0[2];
         end
         default: begin
            out_msg   = msg_p0[0];
            out_ntype = ntype_p0[0];
            out_mux   = mux_p0[0];
         end
      endcase
   end

   assign out_idx = idx_p0;

   // State register and slot index
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_p0  <= 2'd0;
      end else begin
         state_q <= state_d;
         idx_p0  <= idx_d;
      end
   end

   // Block buffer capture; cleared on reset so nothing stale survives
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            msg_p0[i]   <= '0;
            ntype_p0[i] <= '0;
            mux_p0[i]   <= '0;
         end
         count_p0 <= 2'd0;
      end else if (load) begin
         msg_p0[0]   <= msg1_in;
         msg_p0[1]   <= msg2_in;
         msg_p0[2]   <= msg3_in;
         ntype_p0[0] <= ntype_m1_in;
         ntype_p0[1] <= ntype_m2_in;
         ntype_p0[2] <= ntype_m3_in;
         mux_p0[0]   <= mux_m1_in;
         mux_p0[1]   <= mux_m2_in;
         mux_p0[2]   <= mux_m3_in;
         count_p0    <= msg_num_in;
      end
   end

`ifdef MSG_SCHED_STATS_EN
   logic [15:0] blk_cnt_q;
   logic [15:0] msg_cnt_q;

   function automatic logic [15:0] sat_inc(input logic [15:0] val);
      if (val == 16'hFFFF) begin
         return val;
      end
      return val + 16'd1;
   endfunction

   // Saturating counters of accepted beats and transferred messages
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_cnt_q <= 16'd0;
         msg_cnt_q <= 16'd0;
      end else begin
         if (accept) begin
            blk_cnt_q <= sat_inc(blk_cnt_q);
         end
         if (xfer) begin
            msg_cnt_q <= sat_inc(msg_cnt_q);
         end
      end
   end

   assign blk_cnt_out = blk_cnt_q;
   assign msg_cnt_out = msg_cnt_q;
`else
   logic unused_hs;
   assign unused_hs = accept ^ xfer;
`endif

endmodule

// File: tb/tb_msg_slot_scheduler.sv
// tb_msg_slot_scheduler
// Directed table of per-cycle vectors for msg_slot_scheduler plus short
// hand-written sequences for mid-block reset and (with MSG_SCHED_STATS_EN)
// the statistics counters. Inputs change on the falling edge; outputs are
// compared 1 ns later, well away from the rising edge.
module tb_msg_slot_scheduler;

   localparam int MSG_W   = 128;
   localparam int NTYPE_W = 4;
   localparam int MUX_W   = 3;

   logic               clk = 1'b0;
   logic               rst;
   logic               in_valid;
   logic               in_ready;
   logic [MSG_W-1:0]   msg1_in, msg2_in, msg3_in;
   logic [NTYPE_W-1:0] ntype_m1_in, ntype_m2_in, ntype_m3_in;
   logic [MUX_W-1:0]   mux_m1_in, mux_m2_in, mux_m3_in;
   logic [1:0]         msg_num_in;
   logic               out_valid;
   logic               out_ready;
   logic [MSG_W-1:0]   out_msg;
   logic [NTYPE_W-1:0] out_ntype;
   logic [MUX_W-1:0]   out_mux;
   logic [1:0]         out_idx;
   logic               out_last;
`ifdef MSG_SCHED_STATS_EN
   logic [15:0]        blk_cnt_out;
   logic [15:0]        msg_cnt_out;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   msg_slot_scheduler #(.MSG_W(MSG_W), .NTYPE_W(NTYPE_W), .MUX_W(MUX_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .msg1_in(msg1_in), .msg2_in(msg2_in), .msg3_in(msg3_in),
      .ntype_m1_in(ntype_m1_in), .ntype_m2_in(ntype_m2_in), .ntype_m3_in(ntype_m3_in),
      .mux_m1_in(mux_m1_in), .mux_m2_in(mux_m2_in), .mux_m3_in(mux_m3_in),
      .msg_num_in(msg_num_in),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_msg(out_msg), .out_ntype(out_ntype), .out_mux(out_mux),
      .out_idx(out_idx), .out_last(out_last)
`ifdef MSG_SCHED_STATS_EN
      , .blk_cnt_out(blk_cnt_out), .msg_cnt_out(msg_cnt_out)
`endif
   );

   typedef struct packed {
      logic       rst;
      logic       iv;
      logic [7:0] tag;
      logic [1:0] num;
      logic       ordy;
      logic       ev;
      logic       erdy;
      logic [7:0] etag;
      logic [1:0] eidx;
      logic       elast;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t V(input logic r, input logic iv, input logic [7:0] tag,
                              input logic [1:0] num, input logic ordy, input logic ev,
                              input logic erdy, input logic [7:0] etag,
                              input logic [1:0] eidx, input logic elast);
      vec_t v;
      v.rst = r; v.iv = iv; v.tag = tag; v.num = num; v.ordy = ordy;
      v.ev = ev; v.erdy = erdy; v.etag = etag; v.eidx = eidx; v.elast = elast;
      return v;
   endfunction

   // Slot contents are a function of beat tag and slot number
   function automatic logic [MSG_W-1:0] mk_msg(input logic [7:0] tag, input logic [1:0] s);
      return {tag, 118'h0, s};
   endfunction
   function automatic logic [NTYPE_W-1:0] mk_ntype(input logic [7:0] tag, input logic [1:0] s);
      return tag[3:0] ^ {2'b00, s};
   endfunction
   function automatic logic [MUX_W-1:0] mk_mux(input logic [7:0] tag, input logic [1:0] s);
      return tag[6:4] + {1'b0, s};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic apply(input string id, input vec_t v);
      rst         = v.rst;
      in_valid    = v.iv;
      msg_num_in  = v.num;
      out_ready   = v.ordy;
      msg1_in     = mk_msg(v.tag, 2'd0);
      msg2_in     = mk_msg(v.tag, 2'd1);
      msg3_in     = mk_msg(v.tag, 2'd2);
      ntype_m1_in = mk_ntype(v.tag, 2'd0);
      ntype_m2_in = mk_ntype(v.tag, 2'd1);
      ntype_m3_in = mk_ntype(v.tag, 2'd2);
      mux_m1_in   = mk_mux(v.tag, 2'd0);
      mux_m2_in   = mk_mux(v.tag, 2'd1);
      mux_m3_in   = mk_mux(v.tag, 2'd2);
      #1;
      chk({id, " out_valid"}, 128'(out_valid), 128'(v.ev));
      chk({id, " in_ready"}, 128'(in_ready), 128'(v.erdy));
      if (v.ev) begin
         chk({id, " out_msg"}, out_msg, mk_msg(v.etag, v.eidx));
         chk({id, " out_ntype"}, 128'(out_ntype), 128'(mk_ntype(v.etag, v.eidx)));
         chk({id, " out_mux"}, 128'(out_mux), 128'(mk_mux(v.etag, v.eidx)));
         chk({id, " out_idx"}, 128'(out_idx), 128'(v.eidx));
         chk({id, " out_last"}, 128'(out_last), 128'(v.elast));
      end
      @(negedge clk);
   endtask

   task automatic chk_reset_state(input string id);
      chk({id, " out_valid"}, 128'(out_valid), 128'(1'b0));
      chk({id, " in_ready"}, 128'(in_ready), 128'(1'b1));
      chk({id, " out_msg"}, out_msg, 128'h0);
      chk({id, " out_ntype"}, 128'(out_ntype), 128'h0);
      chk({id, " out_mux"}, 128'(out_mux), 128'h0);
      chk({id, " out_idx"}, 128'(out_idx), 128'h0);
      chk({id, " out_last"}, 128'(out_last), 128'h0);
   endtask

   initial begin
      // 3-slot block drained at full rate
      tbl.push_back(V(0,1,8'h11,3,1, 0,1,8'h00,0,0));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,0,8'h11,0,0));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,0,8'h11,1,0));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,1,8'h11,2,1));
      tbl.push_back(V(0,0,8'hEE,3,1, 0,1,8'h00,0,0));
      // 2-slot block under 4 stall cycles; pending beat 99 ignored until last
      tbl.push_back(V(0,1,8'h22,2,0, 0,1,8'h00,0,0));
      for (int i = 0; i < 4; i++)
         tbl.push_back(V(0,1,8'h99,1,0, 1,0,8'h22,0,0));
      tbl.push_back(V(0,1,8'h99,1,1, 1,0,8'h22,0,0));
      tbl.push_back(V(0,1,8'h99,1,1, 1,1,8'h22,1,1));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,1,8'h99,0,1));
      tbl.push_back(V(0,0,8'hEE,3,1, 0,1,8'h00,0,0));
      // back-to-back blocks of 1 then 2, no bubble
      tbl.push_back(V(0,1,8'h33,1,1, 0,1,8'h00,0,0));
      tbl.push_back(V(0,1,8'h44,2,1, 1,1,8'h33,0,1));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,0,8'h44,0,0));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,1,8'h44,1,1));
      tbl.push_back(V(0,0,8'hEE,3,1, 0,1,8'h00,0,0));
      // zero-count beat in IDLE, then a single-message beat
      tbl.push_back(V(0,1,8'h55,0,1, 0,1,8'h00,0,0));
      tbl.push_back(V(0,1,8'h66,1,1, 0,1,8'h00,0,0));
      tbl.push_back(V(0,0,8'hEE,3,1, 1,1,8'h66,0,1));
      tbl.push_back(V(0,0,8'hEE,3,1, 0,1,8'h00,0,0));
      // zero-count beat arriving with the last transfer
      tbl.push_back(V(0,1,8'h77,1,1, 0,1,8'h00,0,0));
      tbl.push_back(V(0,1,8'h88,0,1, 1,1,8'h77,0,1));
      tbl.push_back(V(0,0,8'hEE,3,0, 0,1,8'h00,0,0));

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; msg_num_in = 2'd0;
      msg1_in = '0; msg2_in = '0; msg3_in = '0;
      ntype_m1_in = '0; ntype_m2_in = '0; ntype_m3_in = '0;
      mux_m1_in = '0; mux_m2_in = '0; mux_m3_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_state("reset");
`ifdef MSG_SCHED_STATS_EN
      chk("reset blk_cnt", 128'(blk_cnt_out), 128'h0);
      chk("reset msg_cnt", 128'(msg_cnt_out), 128'h0);
`endif
      @(negedge clk);

      foreach (tbl[i]) apply($sformatf("row%0d", i), tbl[i]);

      // reset after one of three messages has transferred
      apply("rstA0", V(0,1,8'hAA,3,1, 0,1,8'h00,0,0));
      apply("rstA1", V(0,0,8'hEE,3,1, 1,0,8'hAA,0,0));
      apply("rstA2", V(1,0,8'hEE,3,1, 1,0,8'hAA,1,0));
      rst = 1'b0;
      #1;
      chk_reset_state("midrst");
      @(negedge clk);
      apply("rstB0", V(0,1,8'hBB,2,1, 0,1,8'h00,0,0));
      apply("rstB1", V(0,0,8'hEE,3,1, 1,0,8'hBB,0,0));
      apply("rstB2", V(0,0,8'hEE,3,1, 1,1,8'hBB,1,1));
      apply("rstB3", V(0,0,8'hEE,3,1, 0,1,8'h00,0,0));

`ifdef MSG_SCHED_STATS_EN
      // counts 3, 0, 2 fully drained
      apply("st0", V(1,0,8'hEE,3,1, 0,1,8'h00,0,0));
      apply("st1", V(0,1,8'hC1,3,1, 0,1,8'h00,0,0));
      apply("st2", V(0,0,8'hEE,3,1, 1,0,8'hC1,0,0));
      apply("st3", V(0,0,8'hEE,3,1, 1,0,8'hC1,1,0));
      apply("st4", V(0,1,8'hC2,0,1, 1,1,8'hC1,2,1));
      apply("st5", V(0,1,8'hC3,2,1, 0,1,8'h00,0,0));
      apply("st6", V(0,0,8'hEE,3,1, 1,0,8'hC3,0,0));
      apply("st7", V(0,0,8'hEE,3,1, 1,1,8'hC3,1,1));
      apply("st8", V(0,0,8'hEE,3,1, 0,1,8'h00,0,0));
      chk("stats blk_cnt", 128'(blk_cnt_out), 128'd3);
      chk("stats msg_cnt", 128'(msg_cnt_out), 128'd5);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // Hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

endmodule
